// File: rtl/sobel_window_3x3.sv
// Streaming 3x3 Sobel/Prewitt gradient-magnitude engine with frame position tracking and border suppression.
// Optional binarisation output enabled by defining SOBEL_THRESH_EN (adds the thresh port).
module sobel_window_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic              mode,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
`ifdef SOBEL_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
`endif
  output logic              valid_out,
  output logic              sof_out,
  output logic [DATA_W-1:0] dout
);

  localparam int GW = DATA_W + 3;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  // win[row][age]: age 0 is the newest column, age 2 the oldest
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
  logic              known_q, known_d;
  logic              mode_lat_q, mode_lat_d;
  logic              valid1_q, valid1_d, sof1_q, sof1_d, border1_q, border1_d;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic              valid_out_q, valid_out_d, sof_out_q, sof_out_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [GW-1:0]     abs_x, abs_y;
  logic [GW:0]       mag;
  logic [DATA_W-1:0] sat;

  function automatic logic signed [GW-1:0] wsum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c,
                                                 input logic prewitt);
    logic signed [GW-1:0] ea, eb, ec;
    ea = $signed({3'b000, a});
    eb = $signed({3'b000, b});
    ec = $signed({3'b000, c});
    return ea + (prewitt ? eb : (eb <<< 1)) + ec;
  endfunction

  // Stage 1: shift window, advance position, compute gradients from the updated window
  always_comb begin
    win_d      = win_q;
    col_d      = col_q;
    row_d      = row_q;
    known_d    = known_q;
    mode_lat_d = mode_lat_q;
    valid1_d   = valid_in;
    sof1_d     = valid_in & sof_in;
    border1_d  = border1_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][2] = win_q[r][1];
        win_d[r][1] = win_q[r][0];
      end
      win_d[0][0] = din1;
      win_d[1][0] = din2;
      win_d[2][0] = din3;
      if (sof_in) begin
        col_d      = '0;
        row_d      = '0;
        known_d    = 1'b1;
        mode_lat_d = mode;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      // Position is untrusted until the first sof after reset, so suppress output
      border1_d = !known_d || (col_d < CNT_W'(2)) || (row_d == '0) || (row_d == ROW_LAST);
      gx_d = wsum(win_d[0][2], win_d[1][2], win_d[2][2], mode_lat_d)
           - wsum(win_d[0][0], win_d[1][0], win_d[2][0], mode_lat_d);
      gy_d = wsum(win_d[0][0], win_d[0][1], win_d[0][2], mode_lat_d)
           - wsum(win_d[2][0], win_d[2][1], win_d[2][2], mode_lat_d);
    end
  end

  // Stage 2: L1 magnitude with saturation, border forced to zero
  always_comb begin
    abs_x       = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y       = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag         = {1'b0, abs_x} + {1'b0, abs_y};
    sat         = (|mag[GW:DATA_W]) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    valid_out_d = valid1_q;
    sof_out_d   = sof1_q;
    dout_d      = dout_q;
    if (valid1_q) begin
`ifdef SOBEL_THRESH_EN
      dout_d = (!border1_q && (sat >= thresh)) ? {DATA_W{1'b1}} : '0;
`else
      dout_d = border1_q ? '0 : sat;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '{default: '0};
      col_q       <= '0;
      row_q       <= '0;
      known_q     <= 1'b0;
      mode_lat_q  <= 1'b0;
      valid1_q    <= 1'b0;
      sof1_q      <= 1'b0;
      border1_q   <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      valid_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
      dout_q      <= '0;
    end else begin
      win_q       <= win_d;
      col_q       <= col_d;
      row_q       <= row_d;
      known_q     <= known_d;
      mode_lat_q  <= mode_lat_d;
      valid1_q    <= valid1_d;
      sof1_q      <= sof1_d;
      border1_q   <= border1_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      valid_out_q <= valid_out_d;
      sof_out_q   <= sof_out_d;
      dout_q      <= dout_d;
    end
  end

  assign valid_out = valid_out_q;
  assign sof_out   = sof_out_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Scoreboard bench for sobel_window_3x3 on an 8x4 image; expected outputs come from a pixel-level model.
// Define SOBEL_THRESH_EN consistently for RTL and bench to exercise the binarised output.
module tb_sobel_window_3x3;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;

  typedef struct packed {
    int unsigned cyc;
    logic        sof;
    logic [7:0]  d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0, sof_in = 1'b0, mode = 1'b0;
  logic [7:0] din1 = '0, din2 = '0, din3 = '0;
  logic       valid_out, sof_out;
  logic [7:0] dout;
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh = 8'd128;
`endif

  int unsigned cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int img [IMG_H][IMG_W];
  ent_t exp_q[$], obs_q[$];

  sobel_window_3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .mode(mode),
    .din1(din1), .din2(din2), .din3(din3),
`ifdef SOBEL_THRESH_EN
    .thresh(thresh),
`endif
    .valid_out(valid_out), .sof_out(sof_out), .dout(dout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder only; all comparisons live in the test tasks
  always @(negedge clk)
    if (valid_out) obs_q.push_back(ent_t'{cyc: cyc, sof: sof_out, d: dout});

  function automatic int pix(int r, int c);
    if (r < 0 || r >= IMG_H) return 0;
    return img[r][c];
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [7:0] model(int r, int c, logic prewitt);
    int k, gx, gy, m;
    if (c < 2 || r == 0 || r == IMG_H - 1) return 8'd0;
    k  = prewitt ? 1 : 2;
    gx = (img[r-1][c-2] + k*img[r][c-2] + img[r+1][c-2])
       - (img[r-1][c]   + k*img[r][c]   + img[r+1][c]);
    gy = (img[r-1][c] + k*img[r-1][c-1] + img[r-1][c-2])
       - (img[r+1][c] + k*img[r+1][c-1] + img[r+1][c-2]);
    m  = iabs(gx) + iabs(gy);
    if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
    return (m >= int'(thresh)) ? 8'd255 : 8'd0;
`else
    return 8'(m);
`endif
  endfunction

  task automatic set_img(input int kind, input int v);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (kind)
          0: img[r][c] = v;
          1: img[r][c] = (c >= 4) ? v : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic drive_frame(input logic md, input int gap, input int npix, input logic toggle);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      r = i / IMG_W;
      c = i % IMG_W;
      valid_in = 1'b1;
      sof_in   = (i == 0);
      mode     = (toggle && i != 0) ? (md ^ 1'(i % 2)) : md;
      din1 = 8'(pix(r-1, c));
      din2 = 8'(pix(r, c));
      din3 = 8'(pix(r+1, c));
      exp_q.push_back(ent_t'{cyc: cyc + 2, sof: (i == 0), d: model(r, c, md)});
      @(posedge clk); #1;
      for (int g = 0; g < gap; g++) begin
        valid_in = 1'b0;
        sof_in   = 1'($urandom_range(0, 1));
        mode     = 1'($urandom_range(0, 1));
        din1 = 8'($urandom); din2 = 8'($urandom); din3 = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    valid_in = 1'b0;
    sof_in   = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1; sof_in = 1'(i % 3 == 0); mode = 1'(i % 2);
      din1 = 8'($urandom); din2 = 8'($urandom); din3 = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({valid_out, sof_out, dout} !== 10'd0) begin
        n_bad++;
        $display("[TB] FAIL reset_hold: valid=%b sof=%b dout=%0d, want all 0", valid_out, sof_out, dout);
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0; sof_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    set_img(2, 0);
    drive_frame(1'b0, 0, IMG_W*IMG_H, 1'b0);
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != 32) begin
      n_bad++;
      $display("[TB] FAIL reset_frame_count: got %0d pulses, want 32", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL reset_frame: got cyc=%0d sof=%b d=%0d, want cyc=%0d sof=%b d=%0d", o.cyc, o.sof, o.d, e.cyc, e.sof, e.d);
      end
    end
  endtask

  task automatic test_flat();
    $display("[TB] test_flat");
    clear_q();
    set_img(0, 100);
    drive_frame(1'b0, 0, IMG_W*IMG_H, 1'b0);
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("[TB] FAIL flat_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL flat: got cyc=%0d sof=%b d=%0d, want cyc=%0d sof=%b d=%0d", o.cyc, o.sof, o.d, e.cyc, e.sof, e.d);
      end
    end
  endtask

  // Sobel frame followed immediately by a Prewitt frame (back-to-back sof)
  task automatic test_vertical_edge();
    $display("[TB] test_vertical_edge");
    clear_q();
    set_img(1, 50);
    drive_frame(1'b0, 0, IMG_W*IMG_H, 1'b0);
    drive_frame(1'b1, 0, IMG_W*IMG_H, 1'b0);
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("[TB] FAIL edge_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL edge: got cyc=%0d sof=%b d=%0d, want cyc=%0d sof=%b d=%0d", o.cyc, o.sof, o.d, e.cyc, e.sof, e.d);
      end
    end
  endtask

  task automatic test_saturation();
    $display("[TB] test_saturation");
    clear_q();
    set_img(1, 255);
    drive_frame(1'b0, 0, IMG_W*IMG_H, 1'b0);
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("[TB] FAIL sat_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL sat: got cyc=%0d sof=%b d=%0d, want cyc=%0d sof=%b d=%0d", o.cyc, o.sof, o.d, e.cyc, e.sof, e.d);
      end
    end
  endtask

  task automatic test_gaps();
    $display("[TB] test_gaps");
    clear_q();
    set_img(1, 50);
    drive_frame(1'b0, 3, IMG_W*IMG_H, 1'b1);
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("[TB] FAIL gaps_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL gaps: got cyc=%0d sof=%b d=%0d, want cyc=%0d sof=%b d=%0d", o.cyc, o.sof, o.d, e.cyc, e.sof, e.d);
      end
    end
  endtask

  task automatic test_reset_midframe();
    $display("[TB] test_reset_midframe");
    clear_q();
    set_img(2, 0);
    drive_frame(1'b0, 0, 2*IMG_W + 4, 1'b0);
    rst_n = 1'b0;
    // the last two pixels are still in the pipeline and must be discarded
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'($urandom_range(0, 1)); sof_in = 1'($urandom_range(0, 1));
      din1 = 8'($urandom); din2 = 8'($urandom); din3 = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({valid_out, sof_out, dout} !== 10'd0) begin
        n_bad++;
        $display("[TB] FAIL midreset_hold: valid=%b sof=%b dout=%0d, want all 0", valid_out, sof_out, dout);
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0; sof_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_img(2, 0);
    drive_frame(1'b0, 0, IMG_W*IMG_H, 1'b0);
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("[TB] FAIL midreset_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("[TB] FAIL midreset: got cyc=%0d sof=%b d=%0d, want cyc=%0d sof=%b d=%0d", o.cyc, o.sof, o.d, e.cyc, e.sof, e.d);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_flat();
    test_vertical_edge();
    test_saturation();
    test_gaps();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
